// File: rtl/avs_pkg.sv
// Shared constants, sample type and saturating magnitude for the acoustic event-detection path.
package avs_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned SHORT_LOG2  = 4;
  localparam int unsigned LONG_LOG2   = 10;
  localparam int unsigned RATIO_LOG2  = 2;
  localparam int unsigned FLOOR       = 256;
  localparam int unsigned HOLD_CYCLES = 64;

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t           SampleMin = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MagMax    = {1'b0, {(DATA_W-1){1'b1}}};

  // Most-negative input clamps to the largest positive magnitude instead of wrapping.
  function automatic logic [DATA_W-1:0] abs_sat(input sample_t x);
    logic [DATA_W-1:0] raw;
    raw = x;
    if (!x[DATA_W-1]) begin
      return raw;
    end else if (x == SampleMin) begin
      return MagMax;
    end else begin
      return (~raw) + 1'b1;
    end
  endfunction

endpackage

// File: rtl/ema_filter.sv
// Integer exponential moving average: acc += mag - (acc >> Shift); avg = acc >> Shift.
module ema_filter
  import avs_pkg::*;
#(
  parameter int unsigned Shift = SHORT_LOG2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mag,
  output logic [DATA_W-1:0] avg
);

  localparam int unsigned AccW = DATA_W + Shift;

  logic [AccW-1:0] acc_q, acc_d;

  // Steady state stays within (mag << Shift) + 2^Shift - 1, so AccW bits never overflow.
  always_comb begin
    acc_d = acc_q + AccW'(mag) - (acc_q >> Shift);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign avg = acc_q[AccW-1:Shift];

endmodule

// File: rtl/top_level.sv
// STA/LTA acoustic event detector: sample register, short/long EMAs, warm-up gate, comparator.
// Optional output stretch enabled by defining TOPLEVEL_EVENT_HOLD_EN.
module top_level
  import avs_pkg::*;
#(
  parameter int unsigned ShortLog2  = SHORT_LOG2,
  parameter int unsigned LongLog2   = LONG_LOG2,
  parameter int unsigned RatioLog2  = RATIO_LOG2,
  parameter int unsigned Floor      = FLOOR,
  parameter int unsigned HoldCycles = HOLD_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] stream,
  output logic                     eventDetected
);

  localparam int unsigned CmpW = DATA_W + RatioLog2;
  localparam logic [LongLog2:0] WarmMax = {1'b1, {LongLog2{1'b0}}};

  sample_t           x_q;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] short_avg, long_avg;
  logic [LongLog2:0] warm_q, warm_d;
  logic              warm_done;
  logic [CmpW-1:0]   short_ext, long_scaled;
  logic              detect_raw;
  logic              det_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
    end else begin
      x_q <= stream;
    end
  end

  assign mag = abs_sat(x_q);

  ema_filter #(
    .Shift(ShortLog2)
  ) u_ema_short (
    .clock(clock),
    .reset(reset),
    .mag  (mag),
    .avg  (short_avg)
  );

  ema_filter #(
    .Shift(LongLog2)
  ) u_ema_long (
    .clock(clock),
    .reset(reset),
    .mag  (mag),
    .avg  (long_avg)
  );

  // Long EMA is meaningless until it has seen one full time constant of samples.
  assign warm_done = (warm_q == WarmMax);

  always_comb begin
    warm_d = warm_q;
    if (!warm_done) begin
      warm_d = warm_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      warm_q <= '0;
    end else begin
      warm_q <= warm_d;
    end
  end

  assign short_ext   = CmpW'(short_avg);
  assign long_scaled = {long_avg, {RatioLog2{1'b0}}};
  assign detect_raw  = warm_done && (short_avg >= DATA_W'(Floor)) && (short_ext > long_scaled);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_q <= 1'b0;
    end else begin
      det_q <= detect_raw;
    end
  end

`ifdef TOPLEVEL_EVENT_HOLD_EN
  localparam int unsigned HoldW = $clog2(HoldCycles + 1);

  logic [HoldW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (detect_raw) begin
      hold_d = HoldW'(HoldCycles);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign eventDetected = det_q | (hold_q != '0);
`else
  assign eventDetected = det_q;
`endif

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: behavioural STA/LTA model feeds a scoreboard of expected flags.
module tb_top_level;

  logic        clock;
  logic        reset;
  logic [15:0] stream;
  logic        eventDetected;

  int total;
  int bad;
  int cyc;
  logic exp_q[$];

  // Reference model state
  longint m_x, m_acc_s, m_acc_l, m_warm, m_hold;
  bit     m_det, m_out;

  top_level dut (
    .clock        (clock),
    .reset        (reset),
    .stream       (stream),
    .eventDetected(eventDetected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_acc_s = 0; m_acc_l = 0; m_warm = 0; m_hold = 0; m_det = 0; m_out = 0;
  endtask

  task automatic model_step(input logic [15:0] s, input logic r);
    longint mag, sa, la;
    bit raw;
    if (!r) begin
      model_reset();
    end else begin
      if (m_x == -32768) mag = 32767;
      else if (m_x < 0) mag = -m_x;
      else mag = m_x;
      sa  = m_acc_s / 16;
      la  = m_acc_l / 1024;
      raw = (m_warm == 1024) && (sa >= 256) && (sa > la * 4);
      m_acc_s = m_acc_s + mag - sa;
      m_acc_l = m_acc_l + mag - la;
      m_det   = raw;
      if (raw) m_hold = 64;
      else if (m_hold > 0) m_hold--;
      if (m_warm < 1024) m_warm++;
      m_x = longint'($signed(s));
`ifdef TOPLEVEL_EVENT_HOLD_EN
      m_out = m_det || (m_hold != 0);
`else
      m_out = m_det;
`endif
    end
  endtask

  // Drive one sample, queue its model outcome, then compare after the edge.
  task automatic tick(input logic [15:0] s, input logic r);
    logic expv;
    reset  = r;
    stream = s;
    model_step(s, r);
    exp_q.push_back(m_out);
    @(posedge clock);
    #1;
    cyc++;
    expv = exp_q.pop_front();
    check($sformatf("out@%0d", cyc), {31'd0, eventDetected}, {31'd0, expv});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_reset();
    reset  = 1'b0;
    stream = 16'h7FFF;

    // Reset held with full-scale input
    for (int i = 0; i < 10; i++) tick(16'h7FFF, 1'b0);

    // Early burst: silence, then 8000 from cycle 500; gated until warm-up ends
    for (int i = 0; i < 500; i++) tick(16'd0, 1'b1);
    for (int i = 0; i < 500; i++) tick(16'd8000, 1'b1);
    check("early_quiet", {31'd0, eventDetected}, 32'd0);
    for (int i = 0; i < 200; i++) tick(16'd8000, 1'b1);

    // Silence after a fresh reset
    tick(16'd0, 1'b0);
    for (int i = 0; i < 5000; i++) tick(16'd0, 1'b1);
    check("silence_short_avg", {16'd0, dut.u_ema_short.avg}, 32'd0);
    check("silence_long_avg", {16'd0, dut.u_ema_long.avg}, 32'd0);

    // Low-level background, then a loud step
    for (int i = 0; i < 2000; i++) tick((i % 2 == 0) ? 16'd16 : 16'hFFF0, 1'b1);
    tick(16'd8000, 1'b1);
    tick(16'd8000, 1'b1);
    tick(16'd8000, 1'b1);
    check("burst_latency", {31'd0, eventDetected}, 32'd1);
    for (int i = 0; i < 3000; i++) tick(16'd8000, 1'b1);
    check("burst_adapt", {31'd0, eventDetected}, 32'd0);

    // Saturated input -32768
    for (int i = 0; i < 13000; i++) tick(16'h8000, 1'b1);
    check("sat_short_avg", {16'd0, dut.u_ema_short.avg}, 32'd32767);
    check("sat_long_avg", {16'd0, dut.u_ema_long.avg}, 32'd32767);

    // Short burst after warm-up; hold behaviour follows the model
    tick(16'd0, 1'b0);
    for (int i = 0; i < 1100; i++) tick(16'd0, 1'b1);
    for (int i = 0; i < 20; i++) tick(16'd8000, 1'b1);
    for (int i = 0; i < 200; i++) tick(16'd0, 1'b1);

    // Reset mid-event must clear the flag without a clock edge
    for (int i = 0; i < 10; i++) tick(16'd8000, 1'b1);
    check("pre_reset_high", {31'd0, eventDetected}, 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_low", {31'd0, eventDetected}, 32'd0);
    tick(16'd8000, 1'b0);
    for (int i = 0; i < 50; i++) tick(16'd8000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
